ddc_phase_sched: RTL and testbench

Time-multiplexing scheduler for the quad DDC datapath. It keeps a double-buffered table of per-channel phase settings (`pinc`, `poff`) and drives the DDC phase inputs one channel per cycle, round-robin over the active channel count. Each issued channel index goes into a tag FIFO, so every DDC output word comes back labelled with its channel. It sits between the AXI-lite register file, which writes the table, and the quad DDC instance.

---
 rtl/ddc_phase_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_ddc_phase_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_phase_sched.sv
// ddc_phase_sched
//
// Time-multiplexing scheduler for the quad DDC datapath. A double-buffered
// table of per-channel phase settings (pinc/poff) is presented to the DDC one
// channel per cycle, round-robin over the active channel count. Every issued
// channel index is pushed into a first-word-fall-through tag FIFO, so each DDC
// output word can be labelled with the channel it belongs to.
//
// Ports
//   clk, rstn            single clock, synchronous active-low reset
//   cfg_we/addr/pinc/poff shadow-bank table write
//   cfg_nch              shadow active-channel count (sampled on we/commit)
//   cfg_commit           request bank swap at the next frame boundary
//   commit_pending       swap requested but not yet performed
//   run                  scheduling enable
//   pinc, poff, p_valid  registered phase settings to the DDC
//   frame_start          marks the p_valid beat carrying channel 0
//   dds_valid_out        DDC output-valid, pops the tag FIFO
//   ch_out, ch_out_valid channel tag for the current DDC output (combinational)
//   err_underflow        sticky: DDC produced output with no tag outstanding

module ddc_phase_sched #(
  parameter int N_CH      = 16,
  parameter int TAG_DEPTH = 64,
  localparam int AW       = $clog2(N_CH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [19:0]   cfg_pinc,
  input  logic [19:0]   cfg_poff,
  input  logic [AW:0]   cfg_nch,
  input  logic          cfg_commit,
  output logic          commit_pending,
  input  logic          run,
  output logic [19:0]   pinc,
  output logic [19:0]   poff,
  output logic          p_valid,
  output logic          frame_start,
  input  logic          dds_valid_out,
  output logic [AW-1:0] ch_out,
  output logic          ch_out_valid,
  output logic          err_underflow
);

  localparam int DW = $clog2(TAG_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SWAP = 2'd2;

  localparam logic [AW:0] NCH_MAX   = (AW+1)'(N_CH);
  localparam logic [AW:0] NCH_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);
  localparam logic [DW:0] FIFO_FULL = (DW+1)'(TAG_DEPTH);
  localparam logic [DW:0] CNT_ONE   = (DW+1)'(1);
  localparam logic [DW-1:0] PTR_ONE = DW'(1);

  logic [1:0]    state;
  logic          sel;
  logic [AW-1:0] idx;
  logic [AW:0]   nch0;
  logic [AW:0]   nch1;

  // Both banks live in one array; the bank select is the top address bit.
  logic [19:0]   pinc_mem [2*N_CH];
  logic [19:0]   poff_mem [2*N_CH];

  logic [AW-1:0] tag_mem [TAG_DEPTH];
  logic [DW-1:0] wr_ptr;
  logic [DW-1:0] rd_ptr;
  logic [DW:0]   count;

  logic [AW:0]   nch_sat;
  logic [AW:0]   active_nch;
  logic [AW:0]   shadow_nch_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic          frame_last;
  logic          issue;
  logic          pop;

  // Shadow count handling: saturate oversize requests, and look ahead at a
  // same-cycle shadow update so a write during SWAP counts toward the new bank.
  always_comb begin
    nch_sat         = (cfg_nch > NCH_MAX) ? NCH_MAX : cfg_nch;
    active_nch      = sel ? nch1 : nch0;
    shadow_nch_next = sel ? nch0 : nch1;
    if (cfg_we || cfg_commit) begin
      shadow_nch_next = nch_sat;
    end
  end

  // Issue only when the tag FIFO has room, so a push can never overflow it.
  always_comb begin
    fifo_full  = (count == FIFO_FULL);
    fifo_empty = (count == '0);
    frame_last = ({1'b0, idx} == (active_nch - NCH_ONE));
    issue      = (state == ST_RUN) && !fifo_full;
    pop        = dds_valid_out && !fifo_empty;
  end

  // Table RAM: writes always go to the bank that is not currently active.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      pinc_mem[{~sel, cfg_addr}] <= cfg_pinc;
      poff_mem[{~sel, cfg_addr}] <= cfg_poff;
    end
  end

  // Per-bank channel counts, refreshed in the shadow bank on write or commit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      nch0 <= '0;
      nch1 <= '0;
    end else if (cfg_we || cfg_commit) begin
      if (sel) begin
        nch0 <= nch_sat;
      end else begin
        nch1 <= nch_sat;
      end
    end
  end

  // Scheduler FSM: round-robin issue, frame-boundary bank swaps, run/stop.
  // A SWAP clears commit_pending after any new request is considered, so a
  // commit seen during SWAP is dropped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      idx            <= '0;
      sel            <= 1'b0;
      commit_pending <= 1'b0;
      p_valid        <= 1'b0;
      frame_start    <= 1'b0;
      pinc           <= '0;
      poff           <= '0;
    end else begin
      p_valid     <= 1'b0;
      frame_start <= 1'b0;
      if (cfg_commit && !commit_pending) begin
        commit_pending <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (cfg_commit || commit_pending) begin
            state <= ST_SWAP;
          end else if (run && (active_nch != '0)) begin
            state <= ST_RUN;
            idx   <= '0;
          end
        end
        ST_RUN: begin
          if (issue) begin
            p_valid     <= 1'b1;
            frame_start <= (idx == '0);
            pinc        <= pinc_mem[{sel, idx}];
            poff        <= poff_mem[{sel, idx}];
            if (frame_last) begin
              if (commit_pending) begin
                state <= ST_SWAP;
              end else if (!run) begin
                state <= ST_IDLE;
              end else begin
                idx <= '0;
              end
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
        end
        ST_SWAP: begin
          sel            <= ~sel;
          commit_pending <= 1'b0;
          idx            <= '0;
          if (run && (shadow_nch_next != '0)) begin
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Tag FIFO storage; the pushed tag is the index issued on the same edge.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[wr_ptr] <= idx;
    end
  end

  // Tag FIFO pointers, occupancy and the sticky underflow flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (issue) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({issue, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (dds_valid_out && fifo_empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // Fall-through head; forced to zero when no tag is presented so the
  // unreset FIFO RAM never leaks onto ch_out.
  always_comb begin
    ch_out_valid = pop;
    ch_out       = pop ? tag_mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_ddc_phase_sched.sv
// tb_ddc_phase_sched
//
// Directed bench for ddc_phase_sched built with TAG_DEPTH = 8 so back-pressure
// is reachable. A delay-line DDC model feeds dds_valid_out; a monitor keeps a
// queue of issued channels (recovered from the pinc value, whose bits [12:8]
// always hold channel+1 in this bench) and checks every returned tag.

module tb_ddc_phase_sched;

  localparam int N_CH      = 16;
  localparam int TAG_DEPTH = 8;
  localparam int AW        = 4;

  logic          clk;
  logic          rstn;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [19:0]   cfg_pinc;
  logic [19:0]   cfg_poff;
  logic [AW:0]   cfg_nch;
  logic          cfg_commit;
  logic          commit_pending;
  logic          run;
  logic [19:0]   pinc;
  logic [19:0]   poff;
  logic          p_valid;
  logic          frame_start;
  logic          dds_valid_out;
  logic [AW-1:0] ch_out;
  logic          ch_out_valid;
  logic          err_underflow;

  int compared   = 0;
  int mismatched = 0;

  ddc_phase_sched #(
    .N_CH      (N_CH),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_pinc       (cfg_pinc),
    .cfg_poff       (cfg_poff),
    .cfg_nch        (cfg_nch),
    .cfg_commit     (cfg_commit),
    .commit_pending (commit_pending),
    .run            (run),
    .pinc           (pinc),
    .poff           (poff),
    .p_valid        (p_valid),
    .frame_start    (frame_start),
    .dds_valid_out  (dds_valid_out),
    .ch_out         (ch_out),
    .ch_out_valid   (ch_out_valid),
    .err_underflow  (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DDC model: p_valid delayed by ddcLatency cycles, or a manual strobe.
  logic [31:0] delayLine = '0;
  int          ddcLatency = 5;
  logic        ddcEnable  = 1'b0;
  logic        manualDv   = 1'b0;

  always @(posedge clk) delayLine <= {delayLine[30:0], p_valid};

  always_comb begin
    dds_valid_out = ddcEnable ? delayLine[ddcLatency-1] : manualDv;
  end

  typedef struct {
    logic [AW-1:0] ch;
    logic [19:0]   pinc;
    logic [19:0]   poff;
    logic          frameStart;
  } vec_t;

  vec_t vecs[4];
  int   tagQ[$];
  logic monEnable = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One configuration beat: drive, let one edge sample it, release strobes.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                               input logic [19:0] pi, input logic [19:0] po,
                               input logic [AW:0] nch, input logic commit);
    cfg_we     = we;
    cfg_addr   = addr;
    cfg_pinc   = pi;
    cfg_poff   = po;
    cfg_nch    = nch;
    cfg_commit = commit;
    tick();
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic waitFrame(input logic [19:0] first, input int budget);
    int n = 0;
    while (!(p_valid && frame_start && pinc == first) && n < budget) begin
      tick();
      n++;
    end
    compared++;
    if (n >= budget) begin
      mismatched++;
      $display("[TB] FAIL waitFrame: no frame with pinc 0x%0h within %0d cycles", first, budget);
    end
  endtask

  task automatic waitIdle();
    int quiet = 0;
    int n = 0;
    while (quiet < 40 && n < 500) begin
      if (p_valid) quiet = 0;
      else quiet++;
      tick();
      n++;
    end
    compared++;
    if (quiet < 40) begin
      mismatched++;
      $display("[TB] FAIL waitIdle: p_valid still active after %0d cycles", n);
    end
  endtask

  // Tag monitor: every DDC output must carry the oldest issued channel.
  always @(negedge clk) begin
    if (monEnable) begin
      if (p_valid) tagQ.push_back(int'(pinc[12:8]) - 1);
      if (dds_valid_out) begin
        if (tagQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL tag_extra: ch_out_valid=%0d with no issued channel outstanding", ch_out_valid);
        end else begin
          int expCh;
          expCh = tagQ.pop_front();
          checkOutput("ch_out_valid", ch_out_valid, 1);
          checkOutput("ch_out", ch_out, expCh);
        end
      end
      checkOutput("err_underflow_clean", err_underflow, 0);
    end
  end

  initial begin
    #1_000_000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    int expIdx;
    int burst;
    int gap;

    vecs[0] = '{4'd0, 20'h00100, 20'h00000, 1'b1};
    vecs[1] = '{4'd1, 20'h00200, 20'h00010, 1'b0};
    vecs[2] = '{4'd2, 20'h00300, 20'h00020, 1'b0};
    vecs[3] = '{4'd3, 20'h00400, 20'h00030, 1'b0};

    rstn       = 1'b0;
    run        = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_pinc   = '0;
    cfg_poff   = '0;
    cfg_nch    = '0;
    cfg_commit = 1'b0;
    tick(); tick(); tick();

    $display("[TB] reset state");
    checkOutput("rst_p_valid", p_valid, 0);
    checkOutput("rst_pinc", pinc, 0);
    checkOutput("rst_poff", poff, 0);
    checkOutput("rst_frame_start", frame_start, 0);
    checkOutput("rst_commit_pending", commit_pending, 0);
    checkOutput("rst_err_underflow", err_underflow, 0);
    checkOutput("rst_ch_out_valid", ch_out_valid, 0);
    checkOutput("rst_ch_out", ch_out, 0);
    rstn = 1'b1;
    tick();

    $display("[TB] basic round-robin and tag alignment");
    ddcLatency = 5;
    ddcEnable  = 1'b1;
    monEnable  = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, vecs[i].ch, vecs[i].pinc, vecs[i].poff, 5'd4, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 5'd4, 1'b1);
    checkOutput("commit_pending_set", commit_pending, 1);
    run = 1'b1;
    tick();
    checkOutput("commit_pending_clear", commit_pending, 0);
    checkOutput("p_valid_before_first", p_valid, 0);
    tick();
    for (int j = 0; j < 12; j++) begin
      checkOutput("rr_p_valid", p_valid, 1);
      checkOutput("rr_pinc", pinc, vecs[j % 4].pinc);
      checkOutput("rr_poff", poff, vecs[j % 4].poff);
      checkOutput("rr_frame_start", frame_start, vecs[j % 4].frameStart);
      tick();
    end

    $display("[TB] commit at frame end");
    applyStimulus(1'b1, 4'd0, 20'h08100, 20'h00020, 5'd2, 1'b0);
    checkOutput("cm_pinc_idx1", pinc, 20'h00200);
    applyStimulus(1'b1, 4'd1, 20'h08200, 20'h00021, 5'd2, 1'b1);
    checkOutput("cm_pinc_idx2", pinc, 20'h00300);
    checkOutput("cm_pending_mid", commit_pending, 1);
    tick();
    checkOutput("cm_pinc_idx3", pinc, 20'h00400);
    checkOutput("cm_p_valid_idx3", p_valid, 1);
    checkOutput("cm_pending_last", commit_pending, 1);
    tick();
    checkOutput("cm_swap_gap", p_valid, 0);
    checkOutput("cm_pending_fall", commit_pending, 0);
    for (int j = 0; j < 4; j++) begin
      tick();
      checkOutput("cm_new_p_valid", p_valid, 1);
      checkOutput("cm_new_pinc", pinc, (j % 2 == 0) ? 20'h08100 : 20'h08200);
      checkOutput("cm_new_poff", poff, (j % 2 == 0) ? 20'h00020 : 20'h00021);
      checkOutput("cm_new_frame_start", frame_start, (j % 2 == 0) ? 1 : 0);
    end

    $display("[TB] stop mid-frame");
    applyStimulus(1'b0, '0, '0, '0, 5'd4, 1'b1);
    waitFrame(20'h00100, 20);
    tick();
    checkOutput("stop_idx1", pinc, 20'h00200);
    run = 1'b0;
    tick();
    checkOutput("stop_idx2_pinc", pinc, 20'h00300);
    checkOutput("stop_idx2_valid", p_valid, 1);
    tick();
    checkOutput("stop_idx3_pinc", pinc, 20'h00400);
    checkOutput("stop_idx3_valid", p_valid, 1);
    tick();
    checkOutput("stop_idle_valid", p_valid, 0);
    tick();
    checkOutput("stop_idle_valid2", p_valid, 0);

    $display("[TB] channel count saturation");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, AW'(i), 20'(32'h100 * (i + 1)), 20'(i), 5'd31, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 5'd31, 1'b1);
    run = 1'b1;
    waitFrame(20'h00100, 10);
    for (int j = 0; j < 20; j++) begin
      checkOutput("sat_p_valid", p_valid, 1);
      checkOutput("sat_pinc", pinc, 32'h100 * ((j % 16) + 1));
      checkOutput("sat_frame_start", frame_start, (j % 16 == 0) ? 1 : 0);
      tick();
    end

    $display("[TB] back-pressure");
    run = 1'b0;
    waitIdle();
    ddcLatency = 20;
    run = 1'b1;
    waitFrame(20'h00100, 10);
    expIdx = 0;
    burst  = 0;
    while (p_valid && burst < 40) begin
      checkOutput("bp_burst_pinc", pinc, 32'h100 * (expIdx + 1));
      expIdx = (expIdx + 1) % 16;
      burst++;
      tick();
    end
    checkOutput("bp_burst_len", burst, TAG_DEPTH);
    gap = 0;
    while (!p_valid && gap < 40) begin
      gap++;
      tick();
    end
    checkOutput("bp_stall_gap", gap, 14);
    for (int k = 0; k < 80; k++) begin
      if (p_valid) begin
        checkOutput("bp_seq_pinc", pinc, 32'h100 * (expIdx + 1));
        expIdx = (expIdx + 1) % 16;
      end
      tick();
    end

    $display("[TB] underflow");
    run = 1'b0;
    waitIdle();
    monEnable = 1'b0;
    ddcEnable = 1'b0;
    manualDv  = 1'b1;
    #1;
    checkOutput("uf_ch_out_valid", ch_out_valid, 0);
    tick();
    manualDv = 1'b0;
    checkOutput("uf_flag_set", err_underflow, 1);
    tick(); tick();
    checkOutput("uf_flag_held", err_underflow, 1);

    $display("[TB] reset mid-frame");
    ddcLatency = 5;
    ddcEnable  = 1'b1;
    run        = 1'b1;
    waitFrame(20'h00100, 10);
    tick(); tick(); tick();
    rstn = 1'b0;
    run  = 1'b0;
    tick();
    checkOutput("mr_p_valid", p_valid, 0);
    checkOutput("mr_pinc", pinc, 0);
    checkOutput("mr_poff", poff, 0);
    checkOutput("mr_frame_start", frame_start, 0);
    checkOutput("mr_commit_pending", commit_pending, 0);
    checkOutput("mr_err_underflow", err_underflow, 0);
    checkOutput("mr_ch_out_valid", ch_out_valid, 0);
    checkOutput("mr_ch_out", ch_out, 0);
    rstn = 1'b1;
    tick(); tick(); tick(); tick();
    checkOutput("mr_inflight_underflow", err_underflow, 1);
    checkOutput("mr_idle_after", p_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
